// File: rtl/cmos_cap_pkg.sv
// Shared types and constants for the CMOS capture front-end.
package cmos_cap_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        ACTIVE = 2'd2
    } cap_state_t;

    localparam logic MODE_RGB565     = 1'b0;
    localparam logic MODE_LUMA       = 1'b1;
    localparam int   SKIP_FRAMES_DEF = 10;
endpackage

// File: rtl/cmos_capture_roi_if.sv
// Gated pixel stream handed to the DDR writer / recognition engine.
interface cmos_capture_roi_if;
    logic        cmos_frame_vsync;
    logic        cmos_frame_href;
    logic        cmos_frame_valid;
    logic [15:0] cmos_frame_data;

    modport master (
        output cmos_frame_vsync,
        output cmos_frame_href,
        output cmos_frame_valid,
        output cmos_frame_data
    );

    modport slave (
        input cmos_frame_vsync,
        input cmos_frame_href,
        input cmos_frame_valid,
        input cmos_frame_data
    );
endinterface

// File: rtl/cmos_byte_pack.sv
// Pairs registered camera bytes into 16-bit pixels; RGB565 keeps both bytes,
// luma mode keeps only the Y byte of each Y/U or Y/V pair.
module cmos_byte_pack
    import cmos_cap_pkg::*;
(
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        href,
    input  logic [7:0]  din,
    input  logic        mode,
    output logic        pix_done,
    output logic [15:0] pix_data,
    output logic        phase
);
    logic [7:0] hi_byte;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'h00;
        end else begin
            if (clear || !href) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
            end
            if (href && !phase) begin
                hi_byte <= din;
            end
        end
    end

    // Luma completes on the first byte of the pair, RGB565 on the second.
    always_comb begin
        pix_done = 1'b0;
        pix_data = 16'h0000;
        if (mode == MODE_LUMA) begin
            pix_done = href && !phase;
            pix_data = {8'h00, din};
        end else begin
            pix_done = href && phase;
            pix_data = {hi_byte, din};
        end
    end
endmodule

// File: rtl/cmos_capture_roi.sv
// OV5640 DVP capture: start-up frame skip, byte packing, ROI gating, frame stats.
//   state  | meaning
//   IDLE   | capture disabled, waiting for a capture_start rise
//   SKIP   | discarding start-up frames, counting frame starts
//   ACTIVE | capturing; each frame start closes the previous frame
module cmos_capture_roi
    import cmos_cap_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              capture_start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              pix_mode,
    input  logic [CNT_W-1:0]  roi_x0,
    input  logic [CNT_W-1:0]  roi_y0,
    input  logic [CNT_W-1:0]  roi_w,
    input  logic [CNT_W-1:0]  roi_h,
    cmos_capture_roi_if.master pix_out,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       SKIP_LAST = 8'(SKIP_FRAMES - 1);

    logic             vs_r, hr_r, vs_p, hr_p, cs_p;
    logic [7:0]       d_r;
    cap_state_t       state;
    logic [7:0]       skip_cnt;
    logic             in_frame;
    logic [CNT_W-1:0] x, y, x0_s, y0_s, w_s, h_s;
    logic             mode_s, err_acc;
    logic             pix_done, phase;
    logic [15:0]      pix_data;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            hr_r <= 1'b0;
            d_r  <= 8'h00;
            vs_p <= 1'b0;
            hr_p <= 1'b0;
            cs_p <= 1'b0;
        end else begin
            vs_r <= cam_vsync;
            hr_r <= cam_href;
            d_r  <= cam_data;
            vs_p <= vs_r;
            hr_p <= hr_r;
            cs_p <= capture_start;
        end
    end

    logic fs, hr_fall, cs_rise, go_active, active_fs, close_frame, run;
    logic odd_err, sat_err, close_err, x_in, y_in, pix_in;
    logic [CNT_W:0] x_end, y_end;

    assign fs          = vs_r && !vs_p;
    assign hr_fall     = hr_p && !hr_r;
    assign cs_rise     = capture_start && !cs_p;
    assign go_active   = (state == SKIP) && fs && (skip_cnt == SKIP_LAST) && capture_start;
    assign active_fs   = fs && capture_start && ((state == ACTIVE) || go_active);
    assign close_frame = fs && capture_start && (state == ACTIVE) && in_frame;
    assign run         = (state == ACTIVE) && capture_start;

    // A vsync rise with href still high is charged to the frame being closed.
    assign odd_err   = hr_fall && phase;
    assign sat_err   = pix_done && (x == CNT_MAX);
    assign close_err = err_acc || odd_err || sat_err || hr_r;

    assign x_end  = {1'b0, x0_s} + {1'b0, w_s};
    assign y_end  = {1'b0, y0_s} + {1'b0, h_s};
    assign x_in   = (x >= x0_s) && ((w_s == '0) || ({1'b0, x} < x_end));
    assign y_in   = (y >= y0_s) && ((h_s == '0) || ({1'b0, y} < y_end));
    assign pix_in = pix_done && x_in && y_in && run && !active_fs;

    cmos_byte_pack u_pack (
        .cam_pclk (cam_pclk),
        .rst_n    (rst_n),
        .clear    (active_fs),
        .href     (hr_r),
        .din      (d_r),
        .mode     (mode_s),
        .pix_done (pix_done),
        .pix_data (pix_data),
        .phase    (phase)
    );

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            skip_cnt   <= 8'h00;
            in_frame   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            frame_done <= close_frame;
            if (close_frame) begin
                frame_err <= close_err;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (!capture_start) begin
                state    <= IDLE;
                in_frame <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_rise) begin
                            skip_cnt <= 8'h00;
                            state    <= (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
                        end
                    end
                    SKIP: begin
                        if (fs) begin
                            if (skip_cnt == SKIP_LAST) begin
                                state <= ACTIVE;
                            end else begin
                                skip_cnt <= skip_cnt + 8'd1;
                            end
                        end
                    end
                    ACTIVE:  state <= ACTIVE;
                    default: state <= IDLE;
                endcase
                if (active_fs) begin
                    in_frame <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            x0_s    <= '0;
            y0_s    <= '0;
            w_s     <= '0;
            h_s     <= '0;
            mode_s  <= MODE_RGB565;
            err_acc <= 1'b0;
        end else if (active_fs) begin
            x       <= '0;
            y       <= '0;
            x0_s    <= roi_x0;
            y0_s    <= roi_y0;
            w_s     <= roi_w;
            h_s     <= roi_h;
            mode_s  <= pix_mode;
            err_acc <= 1'b0;
        end else begin
            if (hr_fall) begin
                x <= '0;
                y <= (y == CNT_MAX) ? y : y + CNT_W'(1);
            end else if (pix_done && (x != CNT_MAX)) begin
                x <= x + CNT_W'(1);
            end
            err_acc <= err_acc || odd_err || sat_err;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out.cmos_frame_vsync <= 1'b0;
            pix_out.cmos_frame_href  <= 1'b0;
            pix_out.cmos_frame_valid <= 1'b0;
            pix_out.cmos_frame_data  <= 16'h0000;
        end else begin
            pix_out.cmos_frame_vsync <= vs_r && capture_start && ((state == ACTIVE) || go_active);
            pix_out.cmos_frame_href  <= hr_r && y_in && run;
            pix_out.cmos_frame_valid <= pix_in;
            if (pix_in) begin
                pix_out.cmos_frame_data <= pix_data;
            end
        end
    end
endmodule
